// File: rtl/register_file_mp_if.sv
// -----------------------------------------------------------------------------
// register_file_mp_if
// Bus bundle for the multi-port register file.
//   master : the pipeline side. It drives the read addresses, the write port and
//            the reserve request, and receives read data, busy flags and the
//            pending count.
//   slave  : the register file itself.
// Signals:
//   ReadRegister    NUM_READ packed read addresses, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   ReadData        NUM_READ packed read data, same packing
//   ReadBusy        per-port flag, set while the addressed register has a pending producer
//   RegWrite        write enable
//   WriteRegister   write address
//   WriteData       write data
//   Reserve         marks ReserveRegister as pending (a producer has issued)
//   ReserveRegister register to mark pending
//   PendingCount    registered count of pending registers
// -----------------------------------------------------------------------------
interface register_file_mp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2
);
  logic [NUM_READ*ADDR_WIDTH-1:0] ReadRegister;
  logic [NUM_READ*DATA_WIDTH-1:0] ReadData;
  logic [NUM_READ-1:0]            ReadBusy;
  logic                           RegWrite;
  logic [ADDR_WIDTH-1:0]          WriteRegister;
  logic [DATA_WIDTH-1:0]          WriteData;
  logic                           Reserve;
  logic [ADDR_WIDTH-1:0]          ReserveRegister;
  logic [ADDR_WIDTH:0]            PendingCount;

  modport master (
    output ReadRegister, RegWrite, WriteRegister, WriteData, Reserve, ReserveRegister,
    input  ReadData, ReadBusy, PendingCount
  );

  modport slave (
    input  ReadRegister, RegWrite, WriteRegister, WriteData, Reserve, ReserveRegister,
    output ReadData, ReadBusy, PendingCount
  );
endinterface

// File: rtl/register_file_mp.sv
// -----------------------------------------------------------------------------
// register_file_mp
// Parametrised multi-port MIPS register file for the pipelined datapath.
// It has NUM_READ combinational read ports and one write port with a
// same-cycle write-to-read bypass. Register 0 reads as zero. A per-register
// pending-write scoreboard lets the hazard logic stall the consumers of
// long-latency results.
// Ports:
//   Clk    rising-edge clock for all state
//   Reset  asynchronous, active-low reset. It clears the registers, the
//          pending bits and PendingCount.
//   rf     register_file_mp_if.slave. Carries the read, write, reserve and
//          status signals.
// The interface parameters must match this module's parameters.
// -----------------------------------------------------------------------------
module register_file_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2
) (
  input logic               Clk,
  input logic               Reset,
  register_file_mp_if.slave rf
);
  localparam int Depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]          regArray [Depth];
  logic [Depth-1:0]               pendingReg;
  logic [Depth-1:0]               pendingNext;
  logic [ADDR_WIDTH:0]            pendingCountReg;
  logic [ADDR_WIDTH:0]            pendingCountNext;
  logic [NUM_READ*DATA_WIDTH-1:0] readDataBus;
  logic [NUM_READ-1:0]            readBusyBus;
  logic                           writeEn;

  // Writes to register 0 are dropped, so entry 0 keeps its reset value of zero.
  assign writeEn = rf.RegWrite && (rf.WriteRegister != '0);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int r = 0; r < Depth; r++) begin
        regArray[r] <= '0;
      end
    end else if (writeEn) begin
      regArray[rf.WriteRegister] <= rf.WriteData;
    end
  end

  // A reserve takes priority over a completing write to the same register.
  // The new producer supersedes the old one, so the bit must stay set.
  always_comb begin
    pendingNext = pendingReg;
    for (int r = 1; r < Depth; r++) begin
      if (rf.Reserve && (rf.ReserveRegister == ADDR_WIDTH'(r))) begin
        pendingNext[r] = 1'b1;
      end else if (rf.RegWrite && (rf.WriteRegister == ADDR_WIDTH'(r))) begin
        pendingNext[r] = 1'b0;
      end
    end
    pendingNext[0] = 1'b0;
  end

  // The count is taken from the next-state vector. That lets the registered
  // count change on the same edge as the pending bits.
  always_comb begin
    pendingCountNext = '0;
    for (int r = 0; r < Depth; r++) begin
      pendingCountNext = pendingCountNext + (ADDR_WIDTH + 1)'(pendingNext[r]);
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pendingReg      <= '0;
      pendingCountReg <= '0;
    end else begin
      pendingReg      <= pendingNext;
      pendingCountReg <= pendingCountNext;
    end
  end

  for (genvar gi = 0; gi < NUM_READ; gi++) begin : gReadPort
    logic [ADDR_WIDTH-1:0] addr;
    logic                  writeHit;

    assign addr     = rf.ReadRegister[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign writeHit = rf.RegWrite && (rf.WriteRegister == addr);

    assign readDataBus[gi*DATA_WIDTH +: DATA_WIDTH] =
        (addr == '0) ? '0 :
        writeHit     ? rf.WriteData :
                       regArray[addr];

    // A write landing this cycle satisfies the consumer through the bypass,
    // so the consumer is no longer busy. pendingReg[0] is always 0.
    assign readBusyBus[gi] = pendingReg[addr] && !writeHit;
  end

  assign rf.ReadData     = readDataBus;
  assign rf.ReadBusy     = readBusyBus;
  assign rf.PendingCount = pendingCountReg;
endmodule

// File: tb/tb_register_file_mp.sv
// -----------------------------------------------------------------------------
// tb_register_file_mp
// Directed bench for register_file_mp. It has two instances:
//   dutA  default parameters (32-bit data, 2 read ports)
//   dutB  NUM_READ=4, DATA_WIDTH=16
// Expected {ReadData, ReadBusy, PendingCount} tuples are queued as each step
// is driven. They are popped and compared once the outputs have settled.
// -----------------------------------------------------------------------------
module tb_register_file_mp;
  logic clk = 1'b0;
  logic resetA;
  logic resetB;

  always #5 clk = ~clk;

  register_file_mp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2)) rfA ();
  register_file_mp_if #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .NUM_READ(4)) rfB ();

  register_file_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2)) dutA (
    .Clk(clk), .Reset(resetA), .rf(rfA)
  );

  register_file_mp #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .NUM_READ(4)) dutB (
    .Clk(clk), .Reset(resetB), .rf(rfB)
  );

  int tests    = 0;
  int failures = 0;
  logic [127:0] expQ [$];

  task automatic check(input string tag, input logic [127:0] obs);
    logic [127:0] exp;
    tests++;
    if (expQ.size() == 0) begin
      failures++;
      $display("FAIL %s: observed %h, no expected value queued", tag, obs);
    end else begin
      exp = expQ.pop_front();
      assert (obs === exp) else begin
        failures++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
      $display("[TB] %s observed %h", tag, obs);
    end
  endtask

  function automatic logic [127:0] obsA();
    return 128'({rfA.ReadData, rfA.ReadBusy, rfA.PendingCount});
  endfunction

  function automatic logic [127:0] obsB();
    return 128'({rfB.ReadData, rfB.ReadBusy, rfB.PendingCount});
  endfunction

  function automatic logic [127:0] expA(input logic [31:0] d1, input logic [31:0] d0,
                                        input logic [1:0] busy, input logic [5:0] cnt);
    return 128'({d1, d0, busy, cnt});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    resetA = 1'b0;
    resetB = 1'b0;
    rfA.ReadRegister = '0; rfA.RegWrite = 1'b0; rfA.WriteRegister = '0;
    rfA.WriteData = '0; rfA.Reserve = 1'b0; rfA.ReserveRegister = '0;
    rfB.ReadRegister = '0; rfB.RegWrite = 1'b0; rfB.WriteRegister = '0;
    rfB.WriteData = '0; rfB.Reserve = 1'b0; rfB.ReserveRegister = '0;

    // ---- Reset state, then read every register on both ports ----
    tick(); tick();
    expQ.push_back(expA(32'h0, 32'h0, 2'b00, 6'd0));
    check("A_in_reset", obsA());
    @(negedge clk);
    resetA = 1'b1;
    for (int r = 1; r < 32; r++) begin
      rfA.ReadRegister = {5'(r), 5'(r)};
      #1;
      expQ.push_back(expA(32'h0, 32'h0, 2'b00, 6'd0));
      check($sformatf("A_reset_r%0d", r), obsA());
    end

    // ---- Write then read; bypass in the write cycle ----
    tick();
    rfA.RegWrite = 1'b1; rfA.WriteRegister = 5'd5; rfA.WriteData = 32'hDEADBEEF;
    tick();
    rfA.WriteRegister = 5'd6; rfA.WriteData = 32'h12345678;
    rfA.ReadRegister = {5'd6, 5'd5};
    #1;
    expQ.push_back(expA(32'h12345678, 32'hDEADBEEF, 2'b00, 6'd0));
    check("A_read_r5_bypass_r6", obsA());
    tick();
    rfA.RegWrite = 1'b0;
    rfA.ReadRegister = {5'd5, 5'd6};
    #1;
    expQ.push_back(expA(32'hDEADBEEF, 32'h12345678, 2'b00, 6'd0));
    check("A_array_r6_r5", obsA());

    // ---- Register 0: write and reserve are both ignored ----
    rfA.RegWrite = 1'b1; rfA.WriteRegister = 5'd0; rfA.WriteData = 32'hFFFFFFFF;
    rfA.Reserve = 1'b1; rfA.ReserveRegister = 5'd0;
    rfA.ReadRegister = {5'd0, 5'd0};
    #1;
    expQ.push_back(expA(32'h0, 32'h0, 2'b00, 6'd0));
    check("A_r0_write_cycle", obsA());
    tick();
    rfA.RegWrite = 1'b0; rfA.Reserve = 1'b0;
    #1;
    expQ.push_back(expA(32'h0, 32'h0, 2'b00, 6'd0));
    check("A_r0_after", obsA());

    // ---- Scoreboard: reserve r8, then complete it with a write ----
    rfA.Reserve = 1'b1; rfA.ReserveRegister = 5'd8;
    rfA.ReadRegister = {5'd8, 5'd8};
    #1;
    expQ.push_back(expA(32'h0, 32'h0, 2'b00, 6'd0));
    check("A_r8_reserve_cycle", obsA());
    tick();
    rfA.Reserve = 1'b0;
    #1;
    expQ.push_back(expA(32'h0, 32'h0, 2'b11, 6'd1));
    check("A_r8_busy", obsA());
    rfA.RegWrite = 1'b1; rfA.WriteRegister = 5'd8; rfA.WriteData = 32'hA5;
    #1;
    expQ.push_back(expA(32'hA5, 32'hA5, 2'b00, 6'd1));
    check("A_r8_write_unbusy", obsA());
    tick();
    rfA.RegWrite = 1'b0;
    #1;
    expQ.push_back(expA(32'hA5, 32'hA5, 2'b00, 6'd0));
    check("A_r8_cleared", obsA());

    // ---- Reserve and write to r9 in the same cycle: reserve wins ----
    rfA.Reserve = 1'b1; rfA.ReserveRegister = 5'd9;
    tick();
    rfA.RegWrite = 1'b1; rfA.WriteRegister = 5'd9; rfA.WriteData = 32'h77;
    rfA.ReadRegister = {5'd9, 5'd9};
    #1;
    expQ.push_back(expA(32'h77, 32'h77, 2'b00, 6'd1));
    check("A_r9_simul_cycle", obsA());
    tick();
    rfA.RegWrite = 1'b0; rfA.Reserve = 1'b0;
    #1;
    expQ.push_back(expA(32'h77, 32'h77, 2'b11, 6'd1));
    check("A_r9_still_busy", obsA());

    // ---- Async reset mid-cycle with r3, r4 pending and r3=0x55 ----
    rfA.RegWrite = 1'b1; rfA.WriteRegister = 5'd3; rfA.WriteData = 32'h55;
    tick();
    rfA.RegWrite = 1'b0;
    rfA.Reserve = 1'b1; rfA.ReserveRegister = 5'd3;
    tick();
    rfA.ReserveRegister = 5'd4;
    tick();
    rfA.Reserve = 1'b0;
    rfA.ReadRegister = {5'd4, 5'd3};
    #1;
    expQ.push_back(expA(32'h0, 32'h55, 2'b11, 6'd3));
    check("A_before_reset", obsA());
    resetA = 1'b0;
    #1;
    expQ.push_back(expA(32'h0, 32'h0, 2'b00, 6'd0));
    check("A_async_reset", obsA());
    rfA.RegWrite = 1'b1; rfA.WriteRegister = 5'd3; rfA.WriteData = 32'h99;
    tick();
    rfA.RegWrite = 1'b0;
    @(negedge clk);
    resetA = 1'b1;
    #1;
    expQ.push_back(expA(32'h0, 32'h0, 2'b00, 6'd0));
    check("A_write_in_reset_ignored", obsA());
    rfA.RegWrite = 1'b1; rfA.WriteRegister = 5'd3; rfA.WriteData = 32'hAB;
    tick();
    rfA.RegWrite = 1'b0;
    #1;
    expQ.push_back(expA(32'h0, 32'hAB, 2'b00, 6'd0));
    check("A_first_write_after_reset", obsA());

    // ---- dutB: 4 ports, 16-bit data ----
    @(negedge clk);
    resetB = 1'b1;
    tick();
    rfB.RegWrite = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      rfB.WriteRegister = 5'(i);
      rfB.WriteData = 16'(i * 16'h1111);
      tick();
    end
    rfB.WriteRegister = 5'd7; rfB.WriteData = 16'hBEEF;
    tick();
    rfB.RegWrite = 1'b0;
    rfB.Reserve = 1'b1; rfB.ReserveRegister = 5'd2;
    tick();
    rfB.ReserveRegister = 5'd3;
    tick();
    rfB.Reserve = 1'b0;
    rfB.ReadRegister = {5'd4, 5'd3, 5'd2, 5'd1};
    #1;
    expQ.push_back(128'({16'h4444, 16'h3333, 16'h2222, 16'h1111, 4'b0110, 6'd2}));
    check("B_four_ports", obsB());
    rfB.ReadRegister = {5'd7, 5'd7, 5'd7, 5'd7};
    #1;
    expQ.push_back(128'({16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF, 4'b0000, 6'd2}));
    check("B_same_reg_all_ports", obsB());
    rfB.ReadRegister = {5'd4, 5'd3, 5'd2, 5'd1};
    resetB = 1'b0;
    #1;
    expQ.push_back(128'({16'h0, 16'h0, 16'h0, 16'h0, 4'b0000, 6'd0}));
    check("B_async_reset", obsB());

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-port MIPS register file for the pipelined datapath; supersedes the fixed two-read, one-write register file of the single-cycle core. It provides NUM_READ combinational read ports, one write port with same-cycle write-to-read bypass, and register 0 hardwired to zero. A per-register pending-write scoreboard lets the hazard logic stall consumers of long-latency results such as loads.

## Interface
- DATA_WIDTH, 32, width of each register
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
- NUM_READ, 2, number of read ports (1..4)

Ports:
- Clk  in  1  clock; all state updates on the rising edge
- Reset  in  1  asynchronous, active-low reset
- ReadRegister  in  NUM_READ*ADDR_WIDTH  packed read addresses; port k is bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- ReadData  out  NUM_READ*DATA_WIDTH  packed read data, same packing
- ReadBusy  out  NUM_READ  per-port flag: the addressed register has a pending producer
- RegWrite  in  1  write enable
- WriteRegister  in  ADDR_WIDTH  write address
- WriteData  in  DATA_WIDTH  write data
- Reserve  in  1  mark ReserveRegister as pending, i.e. a producer has issued
- ReserveRegister  in  ADDR_WIDTH  register to mark pending
- PendingCount  out  ADDR_WIDTH+1  number of registers currently pending

## Operation
- Storage: 2**ADDR_WIDTH x DATA_WIDTH array plus a pending bit vector of the same depth.
- Read, per port k, combinational:
  - addr==0: ReadData=0.
  - else if RegWrite && WriteRegister==addr: ReadData=WriteData (bypass).
  - else: ReadData=array[addr].
- Write: on a rising edge with RegWrite && WriteRegister!=0, array[WriteRegister]<=WriteData. Writes to register 0 are discarded.
- Scoreboard update on a rising edge, per register r!=0:
  - set if Reserve && ReserveRegister==r;
  - else cleared if RegWrite && WriteRegister==r;
  - else held.
- Reserve and write to the same register in one cycle: reserve wins and the bit stays set, because a new producer supersedes. The data write still occurs.
- Reserve to register 0 is ignored; pending[0] is always 0.
- ReadBusy[k] = pending[addr_k] && !(RegWrite && WriteRegister==addr_k). A completing write un-busies its consumer in the same cycle, consistent with the bypass.
- PendingCount = population count of the pending vector, registered, updated on the same edge as the pending bits.
- Multiple ports may address the same register; each returns identical data and busy.

## Timing
- Read latency 0 cycles (combinational from ReadRegister, RegWrite, WriteRegister and WriteData).
- Write visible through array reads from the cycle after the edge; visible through bypass in the same cycle.
- Pending set or cleared takes effect after the rising edge; ReadBusy reflects the new state in the next cycle.
- Reset (Reset=0), asynchronous: all registers become 0, all pending bits 0, PendingCount=0. ReadData then equals 0 unless bypassed; ReadBusy=0.
- Reset asserted mid-operation discards in-flight reservations immediately. Writes presented during reset are ignored.
- Deassertion is synchronous to the design; the first write is accepted on the first rising edge with Reset=1.

## Test plan
- Reset then read: Reset=0, then release. Read r1..r31 on both ports -> all ReadData=0, ReadBusy=0, PendingCount=0.
- Write/read and bypass: write r5=0xDEADBEEF. Next cycle read r5 -> 0xDEADBEEF. In the same cycle, write r6=0x12345678 while port 1 reads r6 -> 0x12345678 combinationally.
- Register 0: write r0=0xFFFFFFFF, Reserve r0 -> reading r0 gives 0, ReadBusy=0, PendingCount=0.
- Scoreboard: Reserve r8 -> next cycle ReadBusy=1 for port reading r8, PendingCount=1. Write r8=0xA5 -> same cycle ReadBusy=0 and ReadData=0xA5; next cycle PendingCount=0.
- Simultaneous: r9 pending; in one cycle Reserve r9 and write r9=0x77 -> r9 reads 0x77 afterward, still busy, PendingCount unchanged at 1.
- Async reset mid-operation: r3 and r4 pending, r3=0x55. Pulse Reset low between edges -> PendingCount=0 and r3 reads 0 immediately, without waiting for a clock edge. Repeat with NUM_READ=4 and DATA_WIDTH=16 for all ports.
